// File: rtl/pipeline_controller_pkg.sv
// rtl/pipeline_controller_pkg.sv - shared pipeline control types and helpers
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } PipeState;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a source register is really read and names the producer's destination
  function automatic logic srcHit(input logic used, input logic [4:0] src, input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// rtl/pipeline_controller_if.sv - hazard inputs and per-stage control between datapath and controller
interface pipeline_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_br_taken;
  logic             mem_access;
  logic             dmem_ready;
  logic             halt_req;
  logic             resume;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_flush;
  logic [1:0]       state_o;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath side: reports hazards, consumes register controls
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_br_taken, mem_access, dmem_ready, halt_req, resume,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush,
           state_o, mem_timeout, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_br_taken, mem_access, dmem_ready, halt_req, resume,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush,
           state_o, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// rtl/pipeline_controller_hazard_detect.sv - load-use hazard compare between IFID and IDEX
module pipeline_controller_hazard_detect
  import pipeline_controller_pkg::*;
(
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic       idUseRs1,
  input  logic       idUseRs2,
  input  logic       exMemRead,
  input  logic [4:0] exRd,
  output logic       loadUse
);
  // x0 never carries a real dependency, so a load targeting it cannot stall
  assign loadUse = exMemRead && (exRd != REG_ZERO) &&
                   (srcHit(idUseRs1, idRs1, exRd) || srcHit(idUseRs2, idRs2, exRd));
endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_controller_if.slave bus
);
  localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  PipeState         state, nextState, retState, nextRet;
  logic [TMO_W-1:0] tmoCnt, nextTmo;
  logic [DRN_W-1:0] drainCnt, nextDrain;
  logic             memTimeout, nextTimeout;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic             loadUse, memStall, flushHit;
  logic             pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic             ifidFlush, idexFlush, memwbFlush;

  pipeline_controller_hazard_detect uHazard (
    .idRs1     (bus.id_rs1),
    .idRs2     (bus.id_rs2),
    .idUseRs1  (bus.id_use_rs1),
    .idUseRs2  (bus.id_use_rs2),
    .exMemRead (bus.ex_mem_read),
    .exRd      (bus.ex_rd),
    .loadUse   (loadUse)
  );

  assign memStall = bus.mem_access && !bus.dmem_ready;

  // Next-state and per-stage control decode; outputs follow inputs in the same cycle
  always_comb begin
    pcEn        = 1'b1;
    ifidEn      = 1'b1;
    idexEn      = 1'b1;
    exmemEn     = 1'b1;
    memwbEn     = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    memwbFlush  = 1'b0;
    flushHit    = 1'b0;
    nextState   = state;
    nextRet     = retState;
    nextTmo     = tmoCnt;
    nextDrain   = drainCnt;
    nextTimeout = memTimeout;
    case (state)
      RUN: begin
        if (memStall) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
          memwbFlush = 1'b1;
          nextState  = MEM_WAIT;
          nextRet    = RUN;
          nextTmo    = TMO_W'(1);
        end else if (bus.ex_br_taken) begin
          ifidFlush = 1'b1;
          idexFlush = 1'b1;
          flushHit  = 1'b1;
        end else if (loadUse) begin
          pcEn      = 1'b0;
          ifidEn    = 1'b0;
          idexFlush = 1'b1;
        end else if (bus.halt_req) begin
          pcEn      = 1'b0;
          ifidFlush = 1'b1;
          nextState = DRAIN;
          nextDrain = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          nextState = retState;
        end else begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
          memwbFlush = 1'b1;
          nextTmo    = tmoCnt + 1'b1;
          if (tmoCnt == TMO_W'(WAIT_TIMEOUT)) begin
            nextTimeout = 1'b1;
            nextState   = HALTED;
          end
        end
      end
      DRAIN: begin
        pcEn      = 1'b0;
        ifidFlush = 1'b1;
        if (memStall) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
          ifidFlush  = 1'b0;
          memwbFlush = 1'b1;
          nextState  = MEM_WAIT;
          nextRet    = DRAIN;
          nextTmo    = TMO_W'(1);
        end else begin
          if (bus.ex_br_taken) begin
            pcEn      = 1'b1;
            idexFlush = 1'b1;
            flushHit  = 1'b1;
          end else if (loadUse) begin
            ifidEn    = 1'b0;
            ifidFlush = 1'b0;
            idexFlush = 1'b1;
          end
          // A held load-use cycle does not count toward the drain
          if (bus.ex_br_taken || !loadUse) begin
            nextDrain = drainCnt + 1'b1;
            if (drainCnt == DRN_W'(DRAIN_CYCLES - 1)) nextState = HALTED;
          end
        end
      end
      HALTED: begin
        {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
        memwbFlush = 1'b1;
        if (bus.resume) begin
          nextState   = RUN;
          nextTimeout = 1'b0;
        end
      end
    endcase
  end

  // Sequencer state, return target and wait/drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      retState   <= RUN;
      tmoCnt     <= '0;
      drainCnt   <= '0;
      memTimeout <= 1'b0;
    end else begin
      state      <= nextState;
      retState   <= nextRet;
      tmoCnt     <= nextTmo;
      drainCnt   <= nextDrain;
      memTimeout <= nextTimeout;
    end
  end

  // Saturating performance counters; halted cycles are not stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcEn && (state != HALTED) && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if (flushHit && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign bus.pc_en       = pcEn;
  assign bus.ifid_en     = ifidEn;
  assign bus.idex_en     = idexEn;
  assign bus.exmem_en    = exmemEn;
  assign bus.memwb_en    = memwbEn;
  assign bus.ifid_flush  = ifidFlush;
  assign bus.idex_flush  = idexFlush;
  assign bus.memwb_flush = memwbFlush;
  assign bus.state_o     = state;
  assign bus.mem_timeout = memTimeout;
  assign bus.stall_cnt   = stallCnt;
  assign bus.flush_cnt   = flushCnt;
endmodule
